// File: rtl/lockin_sample_buffer.sv
// Ping-pong frame capture buffer feeding the lock-in math chain.
// One bank fills with incoming samples while the consumer reads the other bank by address.
module lockin_sample_buffer #(
    parameter int unsigned BUFFER_DEPTH = 512,
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned ADDR_W       = $clog2(BUFFER_DEPTH),
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_sample_valid,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic                  i_flush,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_data_ready,
    output logic                  o_frame_valid,
    output logic [ADDR_W-1:0]     o_fill_level,
    output logic [CNT_WIDTH-1:0]  o_frame_count
);

    localparam int unsigned MEM_DEPTH = 2 * BUFFER_DEPTH;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BUFFER_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  wr_bank;
    logic [ADDR_W-1:0]     wr_ptr;
    logic                  wr_en_c;
    logic                  frame_done_c;

    // Flush takes priority over a simultaneous sample, which is dropped.
    assign wr_en_c      = i_sample_valid & ~i_flush;
    assign frame_done_c = wr_en_c && (wr_ptr == LAST_IDX);
    assign o_fill_level = wr_ptr;

    // Sample storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[{wr_bank, wr_ptr}] <= i_sample;
        end
    end

    // Fill pointer, bank swap and frame publication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank       <= 1'b0;
            wr_ptr        <= '0;
            o_data_ready  <= 1'b0;
            o_frame_valid <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_data_ready <= 1'b0;
            if (i_flush) begin
                wr_ptr <= '0;
            end else if (frame_done_c) begin
                wr_ptr        <= '0;
                wr_bank       <= ~wr_bank;
                o_data_ready  <= 1'b1;
                o_frame_valid <= 1'b1;
                o_frame_count <= o_frame_count + CNT_WIDTH'(1);
            end else if (wr_en_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

    // Read port uses the pre-swap bank, so a read issued in the swap cycle sees old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= mem[{~wr_bank, i_rd_addr}];
        end
    end

endmodule

// File: tb/tb_lockin_sample_buffer.sv
// Directed bench for lockin_sample_buffer with an 8-sample frame.
// A second instance with a 2-bit frame counter shares the stimulus to exercise counter wrap.
module tb_lockin_sample_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 24;
    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_sample_valid = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic          i_flush = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;

    logic [DW-1:0] o_rd_data;
    logic          o_data_ready;
    logic          o_frame_valid;
    logic [AW-1:0] o_fill_level;
    logic [CW-1:0] o_frame_count;

    logic [DW-1:0] c2_rd_data;
    logic          c2_data_ready;
    logic          c2_frame_valid;
    logic [AW-1:0] c2_fill_level;
    logic [1:0]    c2_frame_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_c2 [5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    lockin_sample_buffer #(
        .BUFFER_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_W(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .i_flush(i_flush), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_data_ready(o_data_ready), .o_frame_valid(o_frame_valid),
        .o_fill_level(o_fill_level), .o_frame_count(o_frame_count)
    );

    lockin_sample_buffer #(
        .BUFFER_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_W(AW), .CNT_WIDTH(2)
    ) dut_c2 (
        .clk(clk), .reset(reset), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .i_flush(i_flush), .i_rd_addr(i_rd_addr), .o_rd_data(c2_rd_data),
        .o_data_ready(c2_data_ready), .o_frame_valid(c2_frame_valid),
        .o_fill_level(c2_fill_level), .o_frame_count(c2_frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic cyc(input logic v, input int s, input logic f, input int a);
        i_sample_valid = v;
        i_sample       = DW'(s);
        i_flush        = f;
        i_rd_addr      = AW'(a);
        @(posedge clk);
        #1;
        if (o_data_ready) pulses++;
    endtask

    task automatic do_reset();
        i_sample_valid = 1'b0;
        i_flush        = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check("rst_ready", 32'(o_data_ready), 0);
        check("rst_valid", 32'(o_frame_valid), 0);
        check("rst_fill", 32'(o_fill_level), 0);
        check("rst_count", 32'(o_frame_count), 0);
        check("rst_rd", 32'(o_rd_data), 0);
        reset = 1'b0;

        // Single frame 1..8
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, k, 1'b0, 0);
            if (k == 7) begin
                check("t1_fill7", 32'(o_fill_level), 7);
                check("t1_noready7", 32'(o_data_ready), 0);
                check("t1_novalid7", 32'(o_frame_valid), 0);
            end
        end
        check("t1_ready", 32'(o_data_ready), 1);
        check("t1_valid", 32'(o_frame_valid), 1);
        check("t1_count", 32'(o_frame_count), 1);
        check("t1_fill0", 32'(o_fill_level), 0);
        cyc(1'b0, 0, 1'b0, 0);
        check("t1_pulse_end", 32'(o_data_ready), 0);
        for (int a = 0; a < 8; a++) begin
            cyc(1'b0, 0, 1'b0, a);
            check("t1_rd", 32'(o_rd_data), 32'(a + 1));
        end
        check("t1_pulses", 32'(pulses), 1);

        // Continuous stream 1..24
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            cyc(1'b1, k, 1'b0, 0);
            if (k % 8 == 0) check("t2_ready", 32'(o_data_ready), 1);
        end
        check("t2_pulses", 32'(pulses), 3);
        check("t2_count", 32'(o_frame_count), 3);
        for (int a = 0; a < 8; a++) begin
            cyc(1'b0, 0, 1'b0, a);
            check("t2_rd", 32'(o_rd_data), 32'(17 + a));
        end

        // Flush of a partial frame
        do_reset();
        for (int k = 1; k <= 5; k++) cyc(1'b1, k, 1'b0, 0);
        check("t3_fill5", 32'(o_fill_level), 5);
        cyc(1'b0, 0, 1'b1, 0);
        check("t3_fill0", 32'(o_fill_level), 0);
        check("t3_valid0", 32'(o_frame_valid), 0);
        for (int k = 100; k <= 107; k++) cyc(1'b1, k, 1'b0, 0);
        check("t3_ready", 32'(o_data_ready), 1);
        check("t3_pulses", 32'(pulses), 1);
        check("t3_count", 32'(o_frame_count), 1);
        for (int a = 0; a < 8; a++) begin
            cyc(1'b0, 0, 1'b0, a);
            check("t3_rd", 32'(o_rd_data), 32'(100 + a));
        end

        // Flush coinciding with the frame-completing sample
        for (int k = 200; k <= 206; k++) cyc(1'b1, k, 1'b0, 0);
        check("t4_fill7", 32'(o_fill_level), 7);
        cyc(1'b1, 207, 1'b1, 0);
        check("t4_noready", 32'(o_data_ready), 0);
        check("t4_fill0", 32'(o_fill_level), 0);
        check("t4_count", 32'(o_frame_count), 1);
        check("t4_valid", 32'(o_frame_valid), 1);
        cyc(1'b0, 0, 1'b0, 7);
        check("t4_rd_kept", 32'(o_rd_data), 107);
        check("t4_pulses", 32'(pulses), 1);

        // Swap while the consumer keeps reading address 3
        do_reset();
        for (int k = 1; k <= 8; k++) cyc(1'b1, k, 1'b0, 0);
        for (int k = 9; k <= 16; k++) begin
            cyc(1'b1, k, 1'b0, 3);
            check("t5_rd_old", 32'(o_rd_data), 4);
        end
        check("t5_ready", 32'(o_data_ready), 1);
        cyc(1'b0, 0, 1'b0, 3);
        check("t5_rd_new", 32'(o_rd_data), 12);
        check("t5_count", 32'(o_frame_count), 2);

        // Asynchronous reset in the middle of a frame
        for (int k = 20; k <= 23; k++) cyc(1'b1, k, 1'b0, 0);
        check("t6_fill4", 32'(o_fill_level), 4);
        i_sample_valid = 1'b0;
        reset = 1'b1;
        #2;
        check("t6_rst_rd", 32'(o_rd_data), 0);
        check("t6_rst_ready", 32'(o_data_ready), 0);
        check("t6_rst_valid", 32'(o_frame_valid), 0);
        check("t6_rst_fill", 32'(o_fill_level), 0);
        check("t6_rst_count", 32'(o_frame_count), 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int k = 30; k <= 36; k++) cyc(1'b1, k, 1'b0, 0);
        check("t6_nopulse7", 32'(pulses), 0);
        check("t6_novalid7", 32'(o_frame_valid), 0);
        cyc(1'b1, 37, 1'b0, 0);
        check("t6_ready8", 32'(o_data_ready), 1);
        check("t6_count", 32'(o_frame_count), 1);

        // 2-bit frame counter wrap over five frames
        do_reset();
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 8; k++) cyc(1'b1, 8 * f + k, 1'b0, 0);
            check("t7_c2_ready", 32'(c2_data_ready), 1);
            check("t7_c2_count", 32'(c2_frame_count), 32'(exp_c2[f]));
        end
        check("t7_count16", 32'(o_frame_count), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lockin_sample_buffer.md
Name: lockin_sample_buffer

Overview:
- Ping-pong capture buffer directly upstream of the lock-in math chain. Collects the audio sample stream into frames of BUFFER_DEPTH samples.
- Publishes each completed frame to the lock-in controller, which provides the address and receives the data / ready signals. The consumer reads by random address while the next frame fills.
- Two banks: the write bank fills; the read bank holds the last complete frame, stable until the next swap.

Parameters:
- BUFFER_DEPTH, 512, samples per frame; power of two, >=4.
- DATA_WIDTH, 24, signed sample width.
- ADDR_W, $clog2(BUFFER_DEPTH), frame address width.
- CNT_WIDTH, 16, frame counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_sample_valid  in  1  qualifies i_sample, one sample per asserted cycle.
- i_sample  in  DATA_WIDTH  signed audio sample.
- i_flush  in  1  synchronous discard of the partially filled write bank.
- i_rd_addr  in  ADDR_W  read address into the read bank.
- o_rd_data  out  DATA_WIDTH  read-bank data for the address presented in the previous cycle.
- o_data_ready  out  1  one-cycle pulse: a new frame is published.
- o_frame_valid  out  1  level: the read bank holds a complete frame.
- o_fill_level  out  ADDR_W  samples currently held in the write bank.
- o_frame_count  out  CNT_WIDTH  frames published since reset; wraps.

Behaviour:
- Storage: 2*BUFFER_DEPTH x DATA_WIDTH inferred synchronous RAM, addressed by {bank, index}. Internal wr_bank bit; read bank = ~wr_bank.
- Reset (async, active-high) sets:
  - wr_bank=0, wr_ptr=0
  - o_rd_data=0, o_data_ready=0, o_frame_valid=0, o_fill_level=0, o_frame_count=0
  - RAM contents are not cleared.
- Write path, on i_sample_valid and not i_flush:
  - RAM[{wr_bank, wr_ptr}] <= i_sample.
  - If wr_ptr == BUFFER_DEPTH-1 (frame complete), in the same edge:
    - wr_ptr <= 0, wr_bank toggles
    - o_frame_valid <= 1, o_frame_count increments modulo 2^CNT_WIDTH
    - o_data_ready pulses high for exactly the next cycle.
  - Otherwise wr_ptr increments.
- o_fill_level = wr_ptr (registered). It reads 0 immediately after a swap.
- Back-to-back samples: a sample valid in the cycle after a swap lands at index 0 of the new write bank. No sample loss at any input rate up to one per clock.
- i_flush:
  - wr_ptr <= 0. wr_bank, read bank, o_frame_valid and o_frame_count are unchanged.
  - Flush wins over a simultaneous i_sample_valid: that sample is discarded, even if it would have completed the frame (no swap, no pulse).
- Read path: o_rd_data <= RAM[{~wr_bank, i_rd_addr}], 1-cycle latency, registered.
  - Reads while o_frame_valid=0 return RAM contents, which are undefined until the first frame is published. The consumer must gate on o_frame_valid / o_data_ready.
- Swap during reads: the read bank switches on the swap edge. A read addressed in the swap cycle returns old-bank data; addresses presented after the swap edge return new-bank data.
- Overrun policy: none. The consumer must finish a frame within BUFFER_DEPTH sample periods; a newer frame silently replaces the read bank.
- Reset mid-frame: the partial frame is discarded, o_frame_valid drops to 0, and no pulse occurs until BUFFER_DEPTH new samples are written.

Test Plan (BUFFER_DEPTH=8, DATA_WIDTH=24):
- Reset, then write samples 1..8 one per cycle -> o_data_ready single pulse the cycle after sample 8; o_frame_valid=1; o_frame_count=1; reads of addr 0..7 return 1..7 then 8 with 1-cycle latency.
- Continuous stream 1..24, no gaps -> pulses after samples 8, 16, 24; o_frame_count=3; after the third pulse the read bank holds 17..24; no sample lost across swaps.
- Write 1..5, assert i_flush, then write 100..107 -> o_fill_level 5 then 0; one pulse after 107; read bank holds 100..107.
- i_flush together with i_sample_valid on the 8th sample -> no pulse, o_fill_level=0, o_frame_count unchanged.
- After frame A (1..8), start reading addr 3 continuously while frame B (9..16) completes -> o_rd_data is 4 up to and including the read addressed in the swap cycle, then 12.
- Assert reset after 4 samples of a second frame -> all outputs 0; the next pulse appears only after 8 further samples.
- Set CNT_WIDTH=2 and publish 5 frames -> o_frame_count sequence 1, 2, 3, 0, 1.
